// File: rtl/pixel_pkg.sv
// Shared types and default sizing for the pixel readout sequencer.
package pixel_pkg;

  localparam int unsigned DEF_N_PIX  = 4;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pix_idx_cntr.sv
// Frame index counter: loads the first index, steps up or down, and flags the final index.
module pix_idx_cntr #(
  parameter int unsigned N_PIX = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             down,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt_c,
  output logic             tc_c,
  output logic             tc_nxt_c
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  logic dir;
  logic dir_nxt;

  // Stepping is suppressed at the terminal index so the count never leaves the frame.
  always_comb begin
    dir_nxt   = dir;
    idx_nxt_c = idx;
    if (load) begin
      dir_nxt   = down;
      idx_nxt_c = down ? LAST_IDX : '0;
    end else if (step && !tc_c) begin
      idx_nxt_c = dir ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
    end
  end

  assign tc_c     = dir ? (idx == '0) : (idx == LAST_IDX);
  assign tc_nxt_c = dir_nxt ? (idx_nxt_c == '0) : (idx_nxt_c == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      dir <= 1'b0;
    end else begin
      idx <= idx_nxt_c;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/pixel_readout_seq.sv
// Snapshots a packed pixel bus on start and streams it out one channel per handshake.
module pixel_readout_seq
  import pixel_pkg::*;
#(
  parameter int unsigned  N_PIX  = DEF_N_PIX,
  parameter int unsigned  DATA_W = DEF_DATA_W,
  localparam int unsigned IDX_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    reverse,
  input  logic [N_PIX*DATA_W-1:0] pix_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              hs;
  logic [IDX_W-1:0]  idx_nxt;
  logic              tc;
  logic              tc_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] snap     [N_PIX];
  logic [DATA_W-1:0] snap_nxt [N_PIX];

  assign hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // start is only honoured in IDLE; a handshake on the terminal index ends the frame.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          load      = 1'b1;
        end
      end
      SEND:    if (hs && tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  pix_idx_cntr #(
    .N_PIX (N_PIX),
    .IDX_W (IDX_W)
  ) u_cntr (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .down      (reverse),
    .step      (hs),
    .idx       (out_idx),
    .idx_nxt_c (idx_nxt),
    .tc_c      (tc),
    .tc_nxt_c  (tc_nxt)
  );

  always_comb begin
    for (int i = 0; i < N_PIX; i++) begin
      snap_nxt[i] = load ? pix_data[i*DATA_W +: DATA_W] : snap[i];
    end
  end

  always_ff @(posedge clk) begin
    snap <= snap_nxt;
  end

  // Index mux looks ahead so out_data is registered alongside out_idx.
  always_comb begin
    data_nxt = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (idx_nxt == IDX_W'(i)) data_nxt = snap_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= (state_nxt == SEND);
      out_data  <= (state_nxt == SEND) ? data_nxt : '0;
      out_last  <= (state_nxt == SEND) && tc_nxt;
      busy      <= (state_nxt == SEND);
      done      <= (state_nxt == DONE);
    end
  end

endmodule
